// File: rtl/stack_engine_if.sv
// Stack handshake and data-memory beat signals shared between the controller side
// and the stack engine.
interface stack_engine_if;
  logic       initialize;
  logic       stack_op_ongoing;
  logic       push_or_pop;
  logic       with_flags;
  logic [7:0] pc_in;
  logic [5:0] flags_in;
  logic       bus_grant;
  logic [7:0] mem_rd_data;
  logic       stack_bus_en;
  logic [7:0] stack_addr;
  logic [7:0] stack_wr_data;
  logic       stack_op_end;
  logic [7:0] pop_pc;
  logic [5:0] pop_flags;
  logic [7:0] sp;
  logic       stack_ovf;
  logic       stack_unf;

  modport master (
    output initialize, stack_op_ongoing, push_or_pop, with_flags, pc_in, flags_in,
           bus_grant, mem_rd_data,
    input  stack_bus_en, stack_addr, stack_wr_data, stack_op_end, pop_pc, pop_flags,
           sp, stack_ovf, stack_unf
  );

  modport slave (
    input  initialize, stack_op_ongoing, push_or_pop, with_flags, pc_in, flags_in,
           bus_grant, mem_rd_data,
    output stack_bus_en, stack_addr, stack_wr_data, stack_op_end, pop_pc, pop_flags,
           sp, stack_ovf, stack_unf
  );
endinterface

// File: rtl/stack_engine.sv
// Stack engine: pushes/pops the return PC (and optionally flags) one byte per bus beat,
// owns the empty-descending stack pointer and flags overflow/underflow.
module stack_engine #(
  parameter logic [7:0] SP_RESET    = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
  input  logic           clk,
  input  logic           rst,
  stack_engine_if.slave  bus_if
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BEAT0   = 3'd1,
    BEAT1   = 3'd2,
    ABORT   = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       is_push_q, is_push_d;
  logic       two_q, two_d;
  logic [5:0] flags_q, flags_d;
  logic [7:0] sp_q, sp_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] pop_pc_q, pop_pc_d;
  logic [5:0] pop_flags_q, pop_flags_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic       start_s, ovf_hit_s, unf_hit_s, in_beat_s, granted_s, final_beat_s;
  logic [8:0] push_floor_s, pop_top_s;

  // Frame-length limit checks; with_flags doubles as n-1.
  always_comb begin
    push_floor_s = {1'b0, STACK_LIMIT} + {8'd0, bus_if.with_flags};
    pop_top_s    = {1'b0, sp_q} + 9'd1 + {8'd0, bus_if.with_flags};
    ovf_hit_s    = ({1'b0, sp_q} < push_floor_s);
    unf_hit_s    = (pop_top_s > {1'b0, SP_RESET});
    start_s      = (state_q == IDLE) && bus_if.stack_op_ongoing;
    in_beat_s    = (state_q == BEAT0) || (state_q == BEAT1);
    granted_s    = in_beat_s && bus_if.bus_grant;
    final_beat_s = (state_q == BEAT1) || ((state_q == BEAT0) && !two_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (bus_if.initialize) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus_if.stack_op_ongoing) begin
          if (bus_if.push_or_pop ? ovf_hit_s : unf_hit_s) state_d = ABORT;
          else                                            state_d = BEAT0;
        end else begin
          state_d = IDLE;
        end
      end
      BEAT0: begin
        if (bus_if.bus_grant) state_d = two_q ? BEAT1 : RELEASE;
        else                  state_d = BEAT0;
      end
      BEAT1: begin
        if (bus_if.bus_grant) state_d = RELEASE;
        else                  state_d = BEAT1;
      end
      ABORT:   state_d = RELEASE;
      RELEASE: begin
        if (!bus_if.stack_op_ongoing) state_d = IDLE;
        else                          state_d = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; the next beat address is derived from the updated sp.
  always_comb begin
    is_push_d   = is_push_q;
    two_d       = two_q;
    flags_d     = flags_q;
    sp_d        = sp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pop_pc_d    = pop_pc_q;
    pop_flags_d = pop_flags_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (start_s) begin
      is_push_d = bus_if.push_or_pop;
      two_d     = bus_if.with_flags;
      flags_d   = bus_if.flags_in;
      wdata_d   = bus_if.pc_in;
      addr_d    = bus_if.push_or_pop ? sp_q : sp_q + 8'd1;
      ovf_d     = ovf_q | (bus_if.push_or_pop & ovf_hit_s);
      unf_d     = unf_q | (!bus_if.push_or_pop & unf_hit_s);
    end else if (granted_s) begin
      sp_d    = is_push_q ? sp_q - 8'd1 : sp_q + 8'd1;
      addr_d  = is_push_q ? sp_d : sp_d + 8'd1;
      wdata_d = {2'b00, flags_q};
      if (!is_push_q) begin
        if ((state_q == BEAT0) && two_q) pop_flags_d = bus_if.mem_rd_data[5:0];
        else                             pop_pc_d    = bus_if.mem_rd_data;
      end else begin
        pop_pc_d = pop_pc_q;
      end
    end else begin
      sp_d = sp_q;
    end
    bus_if.stack_bus_en = in_beat_s && !bus_if.initialize;
    bus_if.stack_op_end = ((final_beat_s && bus_if.bus_grant) || (state_q == ABORT))
                          && !bus_if.initialize;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_push_q   <= 1'b0;
      two_q       <= 1'b0;
      flags_q     <= 6'd0;
      sp_q        <= SP_RESET;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      pop_pc_q    <= 8'd0;
      pop_flags_q <= 6'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (bus_if.initialize) begin
      is_push_q   <= 1'b0;
      two_q       <= 1'b0;
      flags_q     <= 6'd0;
      sp_q        <= SP_RESET;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      pop_pc_q    <= 8'd0;
      pop_flags_q <= 6'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      is_push_q   <= is_push_d;
      two_q       <= two_d;
      flags_q     <= flags_d;
      sp_q        <= sp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pop_pc_q    <= pop_pc_d;
      pop_flags_q <= pop_flags_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus_if.stack_addr    = addr_q;
  assign bus_if.stack_wr_data = wdata_q;
  assign bus_if.pop_pc        = pop_pc_q;
  assign bus_if.pop_flags     = pop_flags_q;
  assign bus_if.sp            = sp_q;
  assign bus_if.stack_ovf     = ovf_q;
  assign bus_if.stack_unf     = unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine: a byte memory answers the beats, expected values are
// hand-computed constants.
module tb_stack_engine;
  logic clk;
  logic rst;
  logic tb_push;
  logic [7:0] mem [0:255];
  int n_cmp;
  int n_bad;
  int end_cyc, bus_cyc, stall_bad;

  stack_engine_if sif();

  stack_engine dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sif.mem_rd_data = mem[sif.stack_addr];

  // Memory model: a granted push beat stores the write data.
  always @(posedge clk) begin
    if (sif.stack_bus_en && sif.bus_grant && tb_push) mem[sif.stack_addr] <= sif.stack_wr_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one handshake from a negedge; cycle 1 is the IDLE detect cycle.
  task automatic do_op(input logic push, input logic wf, input logic [7:0] pc,
                       input logic [5:0] fl, input int stalls, input logic [7:0] st_addr,
                       input logic [7:0] st_wd, input logic [7:0] st_sp,
                       output int e_cyc, output int b_cyc, output int s_bad);
    int left;
    left  = stalls;
    e_cyc = 0;
    b_cyc = 0;
    s_bad = 0;
    tb_push              = push;
    sif.stack_op_ongoing = 1'b1;
    sif.push_or_pop      = push;
    sif.with_flags       = wf;
    sif.pc_in            = pc;
    sif.flags_in         = fl;
    for (int c = 1; c <= 20; c++) begin
      sif.bus_grant = (left == 0);
      #1;
      if (sif.stack_bus_en) b_cyc++;
      if (sif.stack_bus_en && !sif.bus_grant) begin
        left--;
        if (sif.stack_addr !== st_addr || sif.stack_wr_data !== st_wd || sif.sp !== st_sp) s_bad++;
      end
      if (sif.stack_op_end) begin
        e_cyc = c;
        break;
      end
      @(negedge clk);
    end
    if (e_cyc == 0) check_eq("op_timeout", 32'd0, 32'd1);
    @(negedge clk);
    sif.stack_op_ongoing = 1'b0;
    sif.bus_grant        = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tb_push = 1'b0;
    rst = 1'b1;
    sif.initialize = 1'b0;
    sif.stack_op_ongoing = 1'b0;
    sif.push_or_pop = 1'b0;
    sif.with_flags = 1'b0;
    sif.pc_in = 8'd0;
    sif.flags_in = 6'd0;
    sif.bus_grant = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_sp", sif.sp, 32'hFF);
    check_eq("rst_ovf", sif.stack_ovf, 32'd0);
    check_eq("rst_unf", sif.stack_unf, 32'd0);
    check_eq("rst_end", sif.stack_op_end, 32'd0);
    check_eq("rst_bus", sif.stack_bus_en, 32'd0);
    check_eq("rst_pop_pc", sif.pop_pc, 32'd0);
    check_eq("rst_pop_flags", sif.pop_flags, 32'd0);

    // JSR then RTS
    do_op(1'b1, 1'b0, 8'h3A, 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("jsr_end_cyc", end_cyc, 32'd2);
    check_eq("jsr_mem_ff", mem[8'hFF], 32'h3A);
    check_eq("jsr_sp", sif.sp, 32'hFE);
    do_op(1'b0, 1'b0, 8'h00, 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("rts_pop_pc", sif.pop_pc, 32'h3A);
    check_eq("rts_sp", sif.sp, 32'hFF);

    // Interrupt then RTI
    do_op(1'b1, 1'b1, 8'h10, 6'b010101, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("int_end_cyc", end_cyc, 32'd3);
    check_eq("int_mem_ff", mem[8'hFF], 32'h10);
    check_eq("int_mem_fe", mem[8'hFE], 32'h15);
    check_eq("int_sp", sif.sp, 32'hFD);
    do_op(1'b0, 1'b1, 8'h00, 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("rti_end_cyc", end_cyc, 32'd3);
    check_eq("rti_pop_flags", sif.pop_flags, 32'h15);
    check_eq("rti_pop_pc", sif.pop_pc, 32'h10);
    check_eq("rti_sp", sif.sp, 32'hFF);

    // Bus stall for 4 cycles
    do_op(1'b1, 1'b0, 8'h55, 6'd0, 4, 8'hFF, 8'h55, 8'hFF, end_cyc, bus_cyc, stall_bad);
    check_eq("stall_end_cyc", end_cyc, 32'd6);
    check_eq("stall_stable", stall_bad, 32'd0);
    check_eq("stall_bus_cyc", bus_cyc, 32'd5);
    check_eq("stall_mem_ff", mem[8'hFF], 32'h55);
    check_eq("stall_sp", sif.sp, 32'hFE);
    do_op(1'b0, 1'b0, 8'h00, 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("stall_pop_pc", sif.pop_pc, 32'h55);

    // Fill down to the limit, then overflow
    for (int i = 0; i < 63; i++) begin
      do_op(1'b1, 1'b0, 8'(i), 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    end
    check_eq("fill_sp", sif.sp, 32'hC0);
    check_eq("fill_mem_c1", mem[8'hC1], 32'd62);
    do_op(1'b1, 1'b1, 8'h66, 6'h01, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("ovf_flag", sif.stack_ovf, 32'd1);
    check_eq("ovf_end_cyc", end_cyc, 32'd2);
    check_eq("ovf_bus_cyc", bus_cyc, 32'd0);
    check_eq("ovf_sp", sif.sp, 32'hC0);
    do_op(1'b1, 1'b0, 8'hAB, 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("limit_push_end", end_cyc, 32'd2);
    check_eq("limit_mem_c0", mem[8'hC0], 32'hAB);
    check_eq("limit_sp", sif.sp, 32'hBF);
    check_eq("ovf_sticky", sif.stack_ovf, 32'd1);

    // initialize clears everything
    sif.initialize = 1'b1;
    @(negedge clk);
    sif.initialize = 1'b0;
    check_eq("init_sp", sif.sp, 32'hFF);
    check_eq("init_ovf", sif.stack_ovf, 32'd0);
    check_eq("init_pop_pc", sif.pop_pc, 32'd0);

    // Underflow, then a legal push
    do_op(1'b1, 1'b0, 8'h77, 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    do_op(1'b0, 1'b0, 8'h00, 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("pre_unf_pop_pc", sif.pop_pc, 32'h77);
    do_op(1'b0, 1'b0, 8'h00, 6'd0, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("unf_flag", sif.stack_unf, 32'd1);
    check_eq("unf_end_cyc", end_cyc, 32'd2);
    check_eq("unf_bus_cyc", bus_cyc, 32'd0);
    check_eq("unf_pop_pc", sif.pop_pc, 32'h77);
    check_eq("unf_sp", sif.sp, 32'hFF);
    do_op(1'b1, 1'b1, 8'h21, 6'h2A, 0, 8'd0, 8'd0, 8'd0, end_cyc, bus_cyc, stall_bad);
    check_eq("post_unf_end", end_cyc, 32'd3);
    check_eq("post_unf_mem_ff", mem[8'hFF], 32'h21);
    check_eq("post_unf_mem_fe", mem[8'hFE], 32'h2A);
    check_eq("post_unf_sp", sif.sp, 32'hFD);
    check_eq("unf_sticky", sif.stack_unf, 32'd1);

    // rst asserted during BEAT1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_push = 1'b1;
    sif.stack_op_ongoing = 1'b1;
    sif.push_or_pop = 1'b1;
    sif.with_flags = 1'b1;
    sif.pc_in = 8'h44;
    sif.flags_in = 6'h01;
    sif.bus_grant = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sif.bus_grant = 1'b0;
    #1;
    check_eq("beat1_bus", sif.stack_bus_en, 32'd1);
    check_eq("beat1_sp", sif.sp, 32'hFE);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_sp", sif.sp, 32'hFF);
    check_eq("rst_mid_bus", sif.stack_bus_en, 32'd0);
    check_eq("rst_mid_end", sif.stack_op_end, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sif.stack_op_ongoing = 1'b0;
    @(negedge clk);
    check_eq("rst_after_bus", sif.stack_bus_en, 32'd0);
    check_eq("rst_after_sp", sif.sp, 32'hFF);
    check_eq("rst_mem_ff", mem[8'hFF], 32'h44);

    // initialize during BEAT0
    sif.stack_op_ongoing = 1'b1;
    sif.push_or_pop = 1'b1;
    sif.with_flags = 1'b0;
    sif.pc_in = 8'h99;
    sif.bus_grant = 1'b0;
    @(negedge clk);
    #1;
    check_eq("init_beat0_bus", sif.stack_bus_en, 32'd1);
    sif.initialize = 1'b1;
    sif.bus_grant = 1'b1;
    #1;
    check_eq("init_mid_end", sif.stack_op_end, 32'd0);
    check_eq("init_mid_bus", sif.stack_bus_en, 32'd0);
    @(negedge clk);
    sif.initialize = 1'b0;
    sif.stack_op_ongoing = 1'b0;
    sif.bus_grant = 1'b0;
    check_eq("init_mid_sp", sif.sp, 32'hFF);
    @(negedge clk);
    check_eq("init_after_bus", sif.stack_bus_en, 32'd0);
    check_eq("init_mem_ff", mem[8'hFF], 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
